sa_feed_ctrl: RTL

Job sequencer for the output-stationary systolic array of MAC processing elements. It accepts matrix-multiply jobs over a start handshake. For each job it generates the skewed per-row A and per-column B read addresses, valid strobes and `last` flags that feed the array edges. It then signals completion when the bottom-right PE drains. It sits between the operand buffers/feeders and the PE grid, and it pipelines consecutive jobs back-to-back.

---
 rtl/sa_feed_ctrl_if.sv | 41 ++++
 rtl/sa_feed_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sa_feed_ctrl_if.sv
// Job/feed bundle between the job source and the systolic feed controller.
// Slave side is the controller; master side issues jobs and consumes feeds.
interface sa_feed_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 4,
  parameter int LW   = 5
);
  logic                 start_i;
  logic [LW-1:0]        k_len_i;
  logic                 start_ready_o;
  logic [ROWS-1:0]      a_valid_o;
  logic [ROWS-1:0]      a_last_o;
  logic [ROWS*KW-1:0]   a_addr_o;
  logic [COLS-1:0]      b_valid_o;
  logic [COLS-1:0]      b_last_o;
  logic [COLS*KW-1:0]   b_addr_o;
  logic                 done_o;
  logic                 busy_o;
  logic                 err_o;
  logic [31:0]          perf_busy_cycles_o;
  logic [31:0]          perf_jobs_o;

  modport master (
    output start_i, k_len_i,
    input  start_ready_o,
    input  a_valid_o, a_last_o, a_addr_o,
    input  b_valid_o, b_last_o, b_addr_o,
    input  done_o, busy_o, err_o,
    input  perf_busy_cycles_o, perf_jobs_o
  );

  modport slave (
    input  start_i, k_len_i,
    output start_ready_o,
    output a_valid_o, a_last_o, a_addr_o,
    output b_valid_o, b_last_o, b_addr_o,
    output done_o, busy_o, err_o,
    output perf_busy_cycles_o, perf_jobs_o
  );
endinterface

// File: rtl/sa_feed_ctrl.sv
// Skewed A/B feed sequencer for an output-stationary systolic MAC array.
// Optional perf counters are built only when SA_CTRL_PERF_EN is defined.
module sa_feed_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX),
  parameter int LW    = $clog2(K_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sa_feed_ctrl_if.slave bus
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int DV    = (MAXRC > 1) ? MAXRC - 1 : 1;
  localparam int N     = ROWS + COLS - 1;

  typedef enum logic {
    IDLE,
    FEED
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [KW-1:0] kq;
  logic [KW-1:0] kq_n;
  logic [LW-1:0] klen;
  logic [LW-1:0] klen_n;
  logic          err_q;
  logic          err_n;

  logic [LW-1:0] k_sat;
  logic          last_k;
  logic          ready;
  logic          accept;
  logic          s_valid;
  logic          s_last;
  logic [KW-1:0] s_addr;

  logic [DV-1:0]         vpipe;
  logic [DV-1:0][KW-1:0] apipe;
  logic [N-1:0]          lpipe;
  logic [DV:0]           tv;
  logic [DV:0][KW-1:0]   ta;
  logic [N:0]            tl;

  logic                  busy;
  logic                  done;
  logic [ROWS-1:0]       a_valid;
  logic [ROWS-1:0]       a_last;
  logic [ROWS*KW-1:0]    a_addr;
  logic [COLS-1:0]       b_valid;
  logic [COLS-1:0]       b_last;
  logic [COLS*KW-1:0]    b_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      kq    <= '0;
      klen  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      kq    <= kq_n;
      klen  <= klen_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    kq_n    = kq;
    klen_n  = klen;
    err_n   = 1'b0;
    k_sat   = bus.k_len_i;
    if (bus.k_len_i > LW'(K_MAX))
      k_sat = LW'(K_MAX);
    last_k  = (LW'(kq) == klen - LW'(1));
    s_valid = (state == FEED);
    s_last  = s_valid && last_k;
    s_addr  = s_valid ? kq : '0;
    ready   = (state == IDLE) || s_last;
    accept  = bus.start_i && ready;
    if (state == FEED) begin
      kq_n = kq + KW'(1);
      if (last_k) begin
        state_n = IDLE;
        kq_n    = '0;
      end
    end
    // Last feed cycle can hand over straight to the next job.
    if (accept) begin
      if (k_sat == '0) begin
        err_n = 1'b1;
      end else begin
        state_n = FEED;
        kq_n    = '0;
        klen_n  = k_sat;
      end
    end
  end

  assign tv = {vpipe, s_valid};
  assign ta = {apipe, s_addr};
  assign tl = {lpipe, s_last};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpipe <= '0;
      apipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe <= tv[DV-1:0];
      apipe <= ta[DV-1:0];
      lpipe <= tl[N-1:0];
    end
  end

  assign done = lpipe[N-1];
  assign busy = (state == FEED) || (|vpipe) || (|lpipe);

  // Tap r of the shared line is the lane-0 stream delayed r cycles.
  always_comb begin
    a_valid = '0;
    a_last  = '0;
    a_addr  = '0;
    b_valid = '0;
    b_last  = '0;
    b_addr  = '0;
    for (int r = 0; r < ROWS; r++) begin
      a_valid[r]         = tv[r];
      a_last[r]          = tl[r];
      a_addr[r*KW +: KW] = ta[r];
    end
    for (int c = 0; c < COLS; c++) begin
      b_valid[c]         = tv[c];
      b_last[c]          = tl[c];
      b_addr[c*KW +: KW] = ta[c];
    end
  end

  assign bus.start_ready_o = ready;
  assign bus.a_valid_o     = a_valid;
  assign bus.a_last_o      = a_last;
  assign bus.a_addr_o      = a_addr;
  assign bus.b_valid_o     = b_valid;
  assign bus.b_last_o      = b_last;
  assign bus.b_addr_o      = b_addr;
  assign bus.done_o        = done;
  assign bus.busy_o        = busy;
  assign bus.err_o         = err_q;

`ifdef SA_CTRL_PERF_EN
  logic [31:0] pbusy;
  logic [31:0] pjobs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pbusy <= '0;
      pjobs <= '0;
    end else begin
      if (busy && (pbusy != '1))
        pbusy <= pbusy + 32'd1;
      if (done && (pjobs != '1))
        pjobs <= pjobs + 32'd1;
    end
  end

  assign bus.perf_busy_cycles_o = pbusy;
  assign bus.perf_jobs_o        = pjobs;
`else
  assign bus.perf_busy_cycles_o = '0;
  assign bus.perf_jobs_o        = '0;
`endif

endmodule
